// File: rtl/geofence_host.sv
// Host-side transmitter for the geofence engine: two-bank frame buffer, 7-cycle
// X/Y/R streamer, bounded wait for the engine result and a tagged result handshake.
module geofence_host #(
  parameter int R_LEAD     = 1,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [9:0]  in_x,
  input  logic [9:0]  in_y,
  input  logic [10:0] in_r,
  output logic [9:0]  X,
  output logic [9:0]  Y,
  output logic [10:0] R,
  input  logic        valid,
  input  logic        is_inside,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        res_inside,
  output logic        res_timeout,
  output logic [7:0]  res_id,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]  state_reg;
  logic [2:0]  cnt_reg;
  logic [9:0]  wait_reg;
  logic [2:0]  gap_reg;
  logic        gap_ok_reg;
  logic [7:0]  frame_id_reg;
  logic [1:0]  full_reg, full_next;
  logic        wr_bank_reg, rd_bank_reg;
  logic [2:0]  wr_idx_reg;
  logic [9:0]  x_bus_reg, y_bus_reg;
  logic [10:0] r_bus_reg;
  logic        res_valid_reg, res_inside_reg, res_timeout_reg;
  logic [7:0]  res_id_reg;

  logic        accept, start, send_last, load_bus, wait_hit, gap_done, r_in_range;
  logic [2:0]  rd_c, r_sel;
  logic [3:0]  r_idx;
  logic [9:0]  bank_x [2];
  logic [9:0]  bank_y [2];
  logic [10:0] bank_r [2];

  assign in_ready  = ~full_reg[wr_bank_reg];
  assign accept    = in_valid & in_ready;
  assign start     = (state_reg == S_IDLE) & full_reg[rd_bank_reg] & gap_ok_reg & ~res_valid_reg;
  assign send_last = (state_reg == S_SEND) & (cnt_reg == 3'd6);
  assign load_bus  = start | ((state_reg == S_SEND) & (cnt_reg != 3'd6));
  assign wait_hit  = ({1'b0, wait_reg} + 11'd1) >= 11'(TIMEOUT);
  assign gap_done  = ({1'b0, gap_reg} + 4'd1) >= 4'(GAP_CYCLES);

  // Bus registers are loaded one edge ahead with the entry for the coming SEND cycle.
  assign rd_c       = ((state_reg == S_SEND) && (cnt_reg != 3'd6)) ? cnt_reg + 3'd1 : 3'd0;
  assign r_idx      = {1'b0, rd_c} + 4'(R_LEAD);
  assign r_in_range = (r_idx >= 4'd1) && (r_idx <= 4'd6);
  assign r_sel      = r_in_range ? r_idx[2:0] : 3'd0;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic [9:0]  x_mem [7];
      logic [9:0]  y_mem [7];
      logic [10:0] r_mem [7];

      always_ff @(posedge clk) begin
        if (accept && (wr_bank_reg == 1'(gi))) begin
          x_mem[wr_idx_reg] <= in_x;
          y_mem[wr_idx_reg] <= in_y;
          r_mem[wr_idx_reg] <= in_r;
        end
      end

      assign bank_x[gi] = x_mem[rd_c];
      assign bank_y[gi] = y_mem[rd_c];
      assign bank_r[gi] = r_mem[r_sel];
    end
  endgenerate

  // The bank being written is never the one being released: that would need both full.
  always_comb begin
    full_next = full_reg;
    if (accept && (wr_idx_reg == 3'd6)) full_next[wr_bank_reg] = 1'b1;
    if (send_last)                      full_next[rd_bank_reg] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= S_IDLE;
      cnt_reg         <= 3'd0;
      wait_reg        <= 10'd0;
      gap_reg         <= 3'd0;
      gap_ok_reg      <= 1'b1;
      frame_id_reg    <= 8'd0;
      full_reg        <= 2'b00;
      wr_bank_reg     <= 1'b0;
      rd_bank_reg     <= 1'b0;
      wr_idx_reg      <= 3'd0;
      x_bus_reg       <= 10'd0;
      y_bus_reg       <= 10'd0;
      r_bus_reg       <= 11'd0;
      res_valid_reg   <= 1'b0;
      res_inside_reg  <= 1'b0;
      res_timeout_reg <= 1'b0;
      res_id_reg      <= 8'd0;
    end else begin
      full_reg <= full_next;
      if (accept) begin
        if (wr_idx_reg == 3'd6) begin
          wr_idx_reg  <= 3'd0;
          wr_bank_reg <= ~wr_bank_reg;
        end else begin
          wr_idx_reg <= wr_idx_reg + 3'd1;
        end
      end

      if (res_valid_reg && res_ready) res_valid_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_SEND;
            cnt_reg   <= 3'd0;
          end
        end
        S_SEND: begin
          if (cnt_reg == 3'd6) begin
            state_reg   <= S_WAIT;
            rd_bank_reg <= ~rd_bank_reg;
            wait_reg    <= 10'd0;
          end else begin
            cnt_reg <= cnt_reg + 3'd1;
          end
        end
        S_WAIT: begin
          // A valid on the timeout cycle wins over the timeout.
          if (valid || wait_hit) begin
            res_valid_reg   <= 1'b1;
            res_inside_reg  <= valid & is_inside;
            res_timeout_reg <= ~valid;
            res_id_reg      <= frame_id_reg;
            frame_id_reg    <= frame_id_reg + 8'd1;
            state_reg       <= S_GAP;
            gap_reg         <= 3'd0;
            gap_ok_reg      <= 1'b0;
          end else begin
            wait_reg <= wait_reg + 10'd1;
          end
        end
        default: begin
          if (gap_done) begin
            state_reg  <= S_IDLE;
            gap_ok_reg <= 1'b1;
          end else begin
            gap_reg <= gap_reg + 3'd1;
          end
        end
      endcase

      if (load_bus) begin
        x_bus_reg <= bank_x[rd_bank_reg];
        y_bus_reg <= bank_y[rd_bank_reg];
        r_bus_reg <= r_in_range ? bank_r[rd_bank_reg] : 11'd0;
      end else begin
        x_bus_reg <= 10'd0;
        y_bus_reg <= 10'd0;
        r_bus_reg <= 11'd0;
      end
    end
  end

  assign X           = x_bus_reg;
  assign Y           = y_bus_reg;
  assign R           = r_bus_reg;
  assign res_valid   = res_valid_reg;
  assign res_inside  = res_inside_reg;
  assign res_timeout = res_timeout_reg;
  assign res_id      = res_id_reg;
  assign busy        = (state_reg != S_IDLE);

endmodule
